rf_wb_ctrl: RTL and testbench

- Writer for the register-file write port (rd / write_e / write_d): merges single-cycle ALU results and variable-latency load returns into one write per cycle.
- Tracks registers with outstanding loads in a scoreboard and drives per-operand hazard flags to decode.
- Sits between execute/memory and the register file.

---
 rtl/rf_wb_ctrl.sv | 127 ++++++++++++
 tb/tb_rf_wb_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_ctrl.sv
// rtl/rf_wb_ctrl.sv - register-file write-port arbiter with load scoreboard
//
// Merges single-cycle ALU results and variable-latency load returns into one
// registered rf write per cycle, tracks destinations of outstanding loads and
// reports per-operand read hazards to decode.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   alu_we/alu_rd/alu_wd          ALU result (no backpressure, highest priority)
//   ld_issue/ld_issue_rd          load issue, marks rd pending
//   ld_valid/ld_ready/ld_rd/ld_data  load return handshake
//   rs1/rs2, hazard_rs1/hazard_rs2   decode operand hazard query
//   rf_rd/rf_write_e/rf_write_d   registered rf write port
//   err                           sticky protocol-violation flag
module rf_wb_ctrl #(
  parameter int XLEN     = 32,
  parameter int LQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_we,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_wd,
  input  logic            ld_issue,
  input  logic [4:0]      ld_issue_rd,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            hazard_rs1,
  output logic            hazard_rs2,
  output logic [4:0]      rf_rd,
  output logic            rf_write_e,
  output logic [XLEN-1:0] rf_write_d,
  output logic            err
);

  localparam int PW = $clog2(LQ_DEPTH);

  logic [4:0]      lq_rd   [LQ_DEPTH];
  logic [XLEN-1:0] lq_data [LQ_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic [31:0]     pending;

  logic full, empty, accept, accept_live;
  logic alu_sel, head_sel, byp_sel, push;
  logic [31:0] pending_next;

  assign full  = (count == (PW+1)'(LQ_DEPTH));
  assign empty = (count == '0);

  assign ld_ready    = !rst && !full;
  assign accept      = ld_valid && ld_ready;
  // Loads to x0 complete the handshake but never occupy the queue.
  assign accept_live = accept && (ld_rd != 5'd0);

  assign alu_sel  = alu_we && (alu_rd != 5'd0);
  assign head_sel = !alu_sel && !empty;
  assign byp_sel  = !alu_sel && empty && accept_live;
  assign push     = accept_live && !byp_sel;

  // Clear for the load taking the port, then apply issue so a same-cycle
  // set on the same register wins.
  always_comb begin
    pending_next = pending;
    if (head_sel)
      pending_next[lq_rd[rd_ptr]] = 1'b0;
    if (byp_sel)
      pending_next[ld_rd] = 1'b0;
    if (ld_issue && (ld_issue_rd != 5'd0))
      pending_next[ld_issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  // The rf_write_e term covers the cycle the value sits on the port before
  // the rf has stored it.
  assign hazard_rs1 = (rs1 != 5'd0) && (pending[rs1] || (rf_write_e && rf_rd == rs1));
  assign hazard_rs2 = (rs2 != 5'd0) && (pending[rs2] || (rf_write_e && rf_rd == rs2));

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_write_e <= 1'b0;
      rf_rd      <= 5'd0;
      rf_write_d <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pending    <= '0;
      err        <= 1'b0;
    end else begin
      rf_write_e <= alu_sel || head_sel || byp_sel;
      if (alu_sel) begin
        rf_rd      <= alu_rd;
        rf_write_d <= alu_wd;
      end else if (head_sel) begin
        rf_rd      <= lq_rd[rd_ptr];
        rf_write_d <= lq_data[rd_ptr];
      end else if (byp_sel) begin
        rf_rd      <= ld_rd;
        rf_write_d <= ld_data;
      end

      if (push) begin
        lq_rd[wr_ptr]   <= ld_rd;
        lq_data[wr_ptr] <= ld_data;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (head_sel)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !head_sel)
        count <= count + 1'b1;
      else if (!push && head_sel)
        count <= count - 1'b1;

      pending <= pending_next;

      if ((alu_sel && pending[alu_rd]) ||
          (accept_live && !pending[ld_rd]) ||
          (ld_issue && (ld_issue_rd != 5'd0) && pending[ld_issue_rd]))
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// tb/tb_rf_wb_ctrl.sv - directed self-checking bench for rf_wb_ctrl
module tb_rf_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_we;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wd;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [4:0]  rs1, rs2;
  logic        hazard_rs1, hazard_rs2;
  logic [4:0]  rf_rd;
  logic        rf_write_e;
  logic [31:0] rf_write_d;
  logic        err;

  int checks = 0;
  int errors = 0;

  rf_wb_ctrl #(.XLEN(32), .LQ_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_we(alu_we), .alu_rd(alu_rd), .alu_wd(alu_wd),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .rs1(rs1), .rs2(rs2), .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
    .rf_rd(rf_rd), .rf_write_e(rf_write_e), .rf_write_d(rf_write_d),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
    check({tag, "_we"}, 32'(rf_write_e), 32'(we));
    if (we) begin
      check({tag, "_rd"}, 32'(rf_rd), 32'(rd));
      check({tag, "_d"}, rf_write_d, d);
    end
  endtask

  initial begin
    rst = 1'b1; alu_we = 0; alu_rd = 0; alu_wd = 0;
    ld_issue = 0; ld_issue_rd = 0; ld_valid = 0; ld_rd = 0; ld_data = 0;
    rs1 = 0; rs2 = 0;
    tick(); tick();
    check("rst_we", 32'(rf_write_e), 0);
    check("rst_rd", 32'(rf_rd), 0);
    check("rst_d", rf_write_d, 0);
    check("rst_err", 32'(err), 0);
    check("rst_ready", 32'(ld_ready), 0);
    rst = 1'b0; #1;
    check("post_rst_ready", 32'(ld_ready), 1);

    // ALU write and its one-cycle port hazard
    alu_we = 1; alu_rd = 5; alu_wd = 32'h1234;
    tick();
    alu_we = 0; rs1 = 5; #1;
    chk_wr("alu5", 1, 5, 32'h1234);
    check("alu5_haz_c2", 32'(hazard_rs1), 1);
    tick();
    check("alu5_haz_c3", 32'(hazard_rs1), 0);
    check("alu5_idle", 32'(rf_write_e), 0);

    // load issue, then bypassed return
    ld_issue = 1; ld_issue_rd = 7;
    tick();
    ld_issue = 0; rs2 = 7; #1;
    check("ld7_haz_issue", 32'(hazard_rs2), 1);
    tick(); tick();
    check("ld7_haz_wait", 32'(hazard_rs2), 1);
    ld_valid = 1; ld_rd = 7; ld_data = 32'hDEADBEEF; #1;
    check("ld7_ready", 32'(ld_ready), 1);
    tick();
    ld_valid = 0; #1;
    chk_wr("ld7_byp", 1, 7, 32'hDEADBEEF);
    check("ld7_haz_port", 32'(hazard_rs2), 1);
    tick();
    check("ld7_haz_clr", 32'(hazard_rs2), 0);
    check("ld7_idle", 32'(rf_write_e), 0);

    // loads 3,4 queue behind ALU writes 8,9,10
    ld_issue = 1; ld_issue_rd = 3; tick();
    ld_issue_rd = 4; tick();
    ld_issue = 0;
    alu_we = 1; alu_rd = 8; alu_wd = 32'h8; ld_valid = 1; ld_rd = 3; ld_data = 32'h33; #1;
    check("q_ready_a", 32'(ld_ready), 1);
    tick();
    alu_rd = 9; alu_wd = 32'h9; ld_rd = 4; ld_data = 32'h44; #1;
    check("q_ready_b", 32'(ld_ready), 1);
    chk_wr("q_w8", 1, 8, 32'h8);
    tick();
    alu_rd = 10; alu_wd = 32'hA; ld_valid = 0; #1;
    check("q_full", 32'(ld_ready), 0);
    chk_wr("q_w9", 1, 9, 32'h9);
    tick();
    alu_we = 0; #1;
    chk_wr("q_w10", 1, 10, 32'hA);
    check("q_full2", 32'(ld_ready), 0);
    tick();
    chk_wr("q_w3", 1, 3, 32'h33);
    check("q_ready_back", 32'(ld_ready), 1);
    tick();
    chk_wr("q_w4", 1, 4, 32'h44);
    tick();
    check("q_idle", 32'(rf_write_e), 0);
    check("q_err", 32'(err), 0);

    // ALU to x0 leaves port to load 12; load to x0 dropped
    ld_issue = 1; ld_issue_rd = 12; tick();
    ld_issue = 0;
    alu_we = 1; alu_rd = 0; alu_wd = 32'h99; ld_valid = 1; ld_rd = 12; ld_data = 32'hC;
    tick();
    alu_we = 0; ld_valid = 0; #1;
    chk_wr("x0_ld12", 1, 12, 32'hC);
    tick();
    ld_valid = 1; ld_rd = 0; ld_data = 32'h55; #1;
    check("x0_ready", 32'(ld_ready), 1);
    tick();
    ld_valid = 0; #1;
    check("x0_nowr", 32'(rf_write_e), 0);
    check("x0_hold_rd", 32'(rf_rd), 12);
    check("x0_err", 32'(err), 0);

    // WAW against pending load sets sticky err, write still happens
    ld_issue = 1; ld_issue_rd = 7; tick();
    ld_issue = 0;
    alu_we = 1; alu_rd = 7; alu_wd = 32'h77;
    tick();
    alu_we = 0; #1;
    chk_wr("waw7", 1, 7, 32'h77);
    check("waw_err", 32'(err), 1);
    tick();
    check("waw_err_sticky", 32'(err), 1);

    // reset with two loads queued
    ld_issue = 1; ld_issue_rd = 13; tick();
    ld_issue_rd = 14; tick();
    ld_issue = 0;
    alu_we = 1; alu_rd = 20; alu_wd = 32'h20; ld_valid = 1; ld_rd = 13; ld_data = 32'h13;
    tick();
    alu_rd = 21; alu_wd = 32'h21; ld_rd = 14; ld_data = 32'h14;
    tick();
    alu_we = 0; ld_valid = 0; rst = 1;
    tick();
    check("mid_rst_we", 32'(rf_write_e), 0);
    check("mid_rst_err", 32'(err), 0);
    check("mid_rst_ready", 32'(ld_ready), 0);
    rst = 0; rs1 = 13; rs2 = 14; #1;
    check("mid_haz13", 32'(hazard_rs1), 0);
    check("mid_haz14", 32'(hazard_rs2), 0);
    check("mid_ready", 32'(ld_ready), 1);
    rs1 = 7; #1;
    check("mid_haz7", 32'(hazard_rs1), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_stale", 32'(rf_write_e), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
